// File: rtl/interval_timer.sv
// interval_timer: parameterised interval timer with a clock prescaler,
// one-shot and periodic modes, pause/resume, synchronous abort, a
// per-expiry tick and elapsed/expiry-count visibility.
module interval_timer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PRE_W = 8,
  parameter int unsigned EXP_W = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             periodic,
  input  logic [WIDTH-1:0] count,
  input  logic [PRE_W-1:0] prescale,
  output logic             done,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] elapsed,
  output logic [EXP_W-1:0] expiries
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUNNING,
    S_PAUSED,
    S_EXPIRED
  } state_t;

  state_t           state;
  state_t           state_d;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] cycles;
  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_cnt;
  logic             mode_q;
  logic [EXP_W-1:0] exp_q;
  logic             tick_q;

  logic             advance;
  logic             en;
  logic             expire;

  // Next-state logic plus the per-edge counting strobes.
  // A PAUSED edge with pause released also counts, so the period grows by
  // exactly the number of cycles spent in PAUSED.
  always_comb begin
    state_d = state;
    advance = ((state == S_RUNNING) || (state == S_PAUSED)) && !pause;
    en      = advance && (pre_cnt == pre_q);
    expire  = en && (cycles == count_q);
    case (state)
      S_IDLE: begin
        if (start) state_d = S_RUNNING;
      end
      S_RUNNING: begin
        if (pause)                  state_d = S_PAUSED;
        else if (expire && !mode_q) state_d = S_EXPIRED;
      end
      S_PAUSED: begin
        if (!pause) begin
          if (expire && !mode_q) state_d = S_EXPIRED;
          else                   state_d = S_RUNNING;
        end
      end
      S_EXPIRED: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (stop) state_d = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!n_reset) state <= S_IDLE;
    else          state <= state_d;
  end

  // Datapath: configuration latch, prescaler, cycle counter, expiry count, tick.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      count_q <= '0;
      pre_q   <= '0;
      mode_q  <= 1'b0;
      cycles  <= '0;
      pre_cnt <= '0;
      exp_q   <= '0;
      tick_q  <= 1'b0;
    end else if (stop) begin
      cycles  <= '0;
      pre_cnt <= '0;
      exp_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= expire;
      if ((state == S_IDLE) && start) begin
        count_q <= count;
        pre_q   <= prescale;
        mode_q  <= periodic;
        cycles  <= '0;
        pre_cnt <= '0;
        exp_q   <= '0;
      end else if (advance) begin
        if (en) begin
          pre_cnt <= '0;
          if (expire) begin
            cycles <= '0;
            if (exp_q != '1) exp_q <= exp_q + EXP_W'(1);
          end else begin
            cycles <= cycles + WIDTH'(1);
          end
        end else begin
          pre_cnt <= pre_cnt + PRE_W'(1);
        end
      end
    end
  end

  assign done     = (state == S_EXPIRED);
  assign busy     = (state == S_RUNNING) || (state == S_PAUSED);
  assign tick     = tick_q;
  assign elapsed  = cycles;
  assign expiries = exp_q;

endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: two timer instances (wide default and a narrow
// WIDTH=8/PRE_W=2/EXP_W=2 copy) driven by shared stimulus and checked every
// cycle against a counting-based reference model.
module tb_interval_timer;

  logic        clk = 1'b0;
  logic        n_reset, start, stop, pause, periodic;
  logic [31:0] count;
  logic [7:0]  prescale;

  logic        a_done, a_tick, a_busy;
  logic [31:0] a_elapsed;
  logic [15:0] a_expiries;
  logic        b_done, b_tick, b_busy;
  logic [7:0]  b_elapsed;
  logic [1:0]  b_expiries;

  int total = 0;
  int bad   = 0;

  // reference model: 0 idle, 1 armed (running or paused), 2 expired
  int     m_st    = 0;
  bit     m_mode  = 1'b0;
  longint m_c     = 0;
  longint m_p     = 0;
  longint m_n     = 0;  // counting edges since arming or last expiry
  int     m_exp_a = 0;
  int     m_exp_b = 0;
  bit     m_tick  = 1'b0;

  always #5 clk = ~clk;

  interval_timer #(.WIDTH(32), .PRE_W(8), .EXP_W(16)) u_a (
    .clk(clk), .n_reset(n_reset), .start(start), .stop(stop), .pause(pause),
    .periodic(periodic), .count(count), .prescale(prescale),
    .done(a_done), .tick(a_tick), .busy(a_busy), .elapsed(a_elapsed),
    .expiries(a_expiries)
  );

  interval_timer #(.WIDTH(8), .PRE_W(2), .EXP_W(2)) u_b (
    .clk(clk), .n_reset(n_reset), .start(start), .stop(stop), .pause(pause),
    .periodic(periodic), .count(count[7:0]), .prescale(prescale[1:0]),
    .done(b_done), .tick(b_tick), .busy(b_busy), .elapsed(b_elapsed),
    .expiries(b_expiries)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!n_reset) begin
      m_st = 0; m_n = 0; m_exp_a = 0; m_exp_b = 0; m_tick = 0; m_c = 0; m_p = 0; m_mode = 0;
    end else if (stop) begin
      m_st = 0; m_n = 0; m_exp_a = 0; m_exp_b = 0; m_tick = 0;
    end else begin
      m_tick = 0;
      case (m_st)
        0: if (start) begin
          m_c = count; m_p = prescale; m_mode = periodic;
          m_n = 0; m_exp_a = 0; m_exp_b = 0; m_st = 1;
        end
        1: if (!pause) begin
          m_n++;
          if (m_n == (m_c + 1) * (m_p + 1)) begin
            m_n = 0;
            m_tick = 1;
            if (m_exp_a < 65535) m_exp_a++;
            if (m_exp_b < 3) m_exp_b++;
            if (!m_mode) m_st = 2;
          end
        end
        default: if (!start) m_st = 0;
      endcase
    end
  endtask

  task automatic step();
    longint el;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    el = (m_st == 1) ? m_n / (m_p + 1) : 0;
    chk("a_done", a_done, (m_st == 2));
    chk("a_busy", a_busy, (m_st == 1));
    chk("a_tick", a_tick, m_tick);
    chk("a_elapsed", a_elapsed, el);
    chk("a_expiries", a_expiries, m_exp_a);
    chk("b_done", b_done, (m_st == 2));
    chk("b_busy", b_busy, (m_st == 1));
    chk("b_tick", b_tick, m_tick);
    chk("b_elapsed", b_elapsed, el);
    chk("b_expiries", b_expiries, m_exp_b);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic arm(input logic [31:0] c, input logic [7:0] p, input logic per, input logic hold);
    count = c; prescale = p; periodic = per; start = 1'b1;
    step();
    if (!hold) start = 1'b0;
  endtask

  task automatic abort();
    stop = 1'b1; start = 1'b0; pause = 1'b0;
    step();
    stop = 1'b0;
  endtask

  initial begin
    n_reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; periodic = 1'b0;
    count = '0; prescale = '0;
    @(negedge clk);
    steps(2);
    chk("rst_busy", a_busy, 0);
    chk("rst_elapsed", a_elapsed, 0);
    n_reset = 1'b1;
    steps(2);

    // reset in the middle of a count, then re-arm cleanly
    arm(10, 0, 0, 0);
    steps(4);
    chk("mid_elapsed", a_elapsed, 4);
    n_reset = 1'b0;
    step();
    chk("rst_mid_busy", a_busy, 0);
    chk("rst_mid_elapsed", a_elapsed, 0);
    n_reset = 1'b1;
    arm(2, 0, 0, 0);
    steps(3);
    chk("rearm_done", a_done, 1);
    steps(2);

    // one-shot with start held high
    arm(5, 0, 0, 1);
    steps(5);
    chk("os_done_early", a_done, 0);
    step();
    chk("os_tick", a_tick, 1);
    chk("os_done", a_done, 1);
    chk("os_exp", a_expiries, 1);
    steps(3);
    chk("os_hold_done", a_done, 1);
    chk("os_hold_tick", a_tick, 0);
    start = 1'b0;
    step();
    chk("os_idle_done", a_done, 0);
    chk("os_idle_busy", a_busy, 0);

    // periodic, period 8 clocks; narrow copy saturates at 3
    arm(3, 1, 1, 0);
    steps(40);
    chk("per_exp_a", a_expiries, 5);
    chk("per_exp_b", b_expiries, 3);
    chk("per_busy", a_busy, 1);
    chk("per_done", a_done, 0);
    abort();

    // pause for 7 cycles after elapsed reaches 4
    arm(9, 0, 0, 0);
    steps(4);
    pause = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("pause_frozen", a_elapsed, 4);
    end
    pause = 1'b0;
    steps(5);
    chk("pause_not_yet", a_done, 0);
    step();
    chk("pause_expiry", a_tick, 1);
    chk("pause_done", a_done, 1);
    steps(2);

    // stop landing on an expiry edge
    arm(3, 0, 1, 0);
    steps(3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_tick", a_tick, 0);
    chk("stop_exp", a_expiries, 0);
    chk("stop_busy", a_busy, 0);
    steps(2);

    // count=0, prescale=0, periodic: tick every cycle
    arm(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("cnt0_tick", a_tick, 1);
    end
    abort();

    // full-range count on the 8-bit copy: 256 clocks, no wrap
    arm(255, 0, 0, 0);
    steps(255);
    chk("max_b_done_early", b_done, 0);
    chk("max_b_elapsed", b_elapsed, 255);
    step();
    chk("max_b_done", b_done, 1);
    chk("max_b_elapsed0", b_elapsed, 0);
    steps(2);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      n_reset = ($urandom_range(0, 299) != 0);
      stop    = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      if ($urandom_range(0, 5) == 0) start = ~start;
      periodic = 1'($urandom_range(0, 1));
      count    = $urandom_range(0, 12);
      prescale = 8'($urandom_range(0, 3));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
